// File: rtl/regfile_sweep.sv
// Parameterised register file: two combinational read ports, one write port,
// hardwired zero register, optional write bypass and a one-per-cycle clear sweep.
module regfile_sweep #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5,
  parameter int ZERO_REG   = 31,
  parameter int BYPASS     = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] ReadRegister1,
  input  logic [ADDR_WIDTH-1:0] ReadRegister2,
  output logic [DATA_WIDTH-1:0] ReadData1,
  output logic [DATA_WIDTH-1:0] ReadData2,
  input  logic [ADDR_WIDTH-1:0] WriteRegister,
  input  logic [DATA_WIDTH-1:0] WriteData,
  input  logic                  RegWrite,
  input  logic                  clear_start,
  output logic                  clear_busy,
  output logic                  clear_done
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;
  localparam bit ZERO_EN  = (ZERO_REG >= 0) && (ZERO_REG < NUM_REGS);
  localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(ZERO_REG);
  localparam bit BYP_EN   = (BYPASS != 0);

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    DONE
  } state_t;

  state_t state, state_n;
  logic [ADDR_WIDTH-1:0] ptr, ptr_n;
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  logic wr_req, wr_en;
  logic zero1, zero2, byp1, byp2;

  assign clear_busy = (state == SWEEP);
  assign clear_done = (state == DONE);

  assign wr_req = RegWrite && !clear_busy;
  assign wr_en  = wr_req && !(ZERO_EN && (WriteRegister == ZERO_ADDR));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      ptr   <= '0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
    end
  end

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    unique case (state)
      IDLE: begin
        if (clear_start) begin
          state_n = SWEEP;
          ptr_n   = '0;
        end
      end
      SWEEP: begin
        ptr_n = ptr + ADDR_WIDTH'(1);
        if (&ptr) state_n = DONE;
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Sweep and external writes are exclusive: writes are dropped while busy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (clear_busy) begin
      regs[ptr] <= '0;
    end else if (wr_en) begin
      regs[WriteRegister] <= WriteData;
    end
  end

  assign zero1 = ZERO_EN && (ReadRegister1 == ZERO_ADDR);
  assign zero2 = ZERO_EN && (ReadRegister2 == ZERO_ADDR);
  assign byp1  = BYP_EN && wr_req && (WriteRegister == ReadRegister1);
  assign byp2  = BYP_EN && wr_req && (WriteRegister == ReadRegister2);

  assign ReadData1 = zero1 ? '0 : (byp1 ? WriteData : regs[ReadRegister1]);
  assign ReadData2 = zero2 ? '0 : (byp2 ? WriteData : regs[ReadRegister2]);

endmodule

// File: tb/tb_regfile_sweep.sv
// Scoreboard bench for regfile_sweep: bypassing and non-bypassing instances
// share stimulus and are checked against an array-based reference model.
module tb_regfile_sweep;

  localparam int DW = 64;
  localparam int AW = 5;
  localparam int NR = 32;
  localparam int ZR = 31;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [AW-1:0] ReadRegister1, ReadRegister2, WriteRegister;
  logic [DW-1:0] WriteData;
  logic          RegWrite, clear_start;
  logic [DW-1:0] ReadData1, ReadData2, nb_rd1, nb_rd2;
  logic          clear_busy, clear_done, nb_busy, nb_done;

  always #5 clk = ~clk;

  regfile_sweep #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_REG(ZR), .BYPASS(1)) dut (
    .clk(clk), .reset_n(reset_n),
    .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
    .ReadData1(ReadData1), .ReadData2(ReadData2),
    .WriteRegister(WriteRegister), .WriteData(WriteData), .RegWrite(RegWrite),
    .clear_start(clear_start), .clear_busy(clear_busy), .clear_done(clear_done)
  );

  regfile_sweep #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_REG(ZR), .BYPASS(0)) dut_nb (
    .clk(clk), .reset_n(reset_n),
    .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
    .ReadData1(nb_rd1), .ReadData2(nb_rd2),
    .WriteRegister(WriteRegister), .WriteData(WriteData), .RegWrite(RegWrite),
    .clear_start(clear_start), .clear_busy(nb_busy), .clear_done(nb_done)
  );

  typedef struct {
    logic [DW-1:0] rd1, rd2, nb1, nb2;
    logic          busy, done;
  } exp_t;

  exp_t q[$];
  logic [DW-1:0] mem [NR];
  // sc: -1 idle, 0..NR-1 sweep cycle index, NR the done cycle
  int sc = -1;
  int checks = 0;
  int errors = 0;

  function automatic bit m_busy();
    return (sc >= 0) && (sc < NR);
  endfunction

  function automatic logic [DW-1:0] m_read(input logic [AW-1:0] a, input bit byp);
    if (int'(a) == ZR) return '0;
    if (byp && RegWrite && !m_busy() && WriteRegister == a) return WriteData;
    return mem[a];
  endfunction

  task automatic step(input bit rst, input bit we, input logic [AW-1:0] wa,
                      input logic [DW-1:0] wd, input logic [AW-1:0] a1,
                      input logic [AW-1:0] a2, input bit st);
    exp_t e;
    reset_n = !rst;
    RegWrite = we;
    WriteRegister = wa;
    WriteData = wd;
    ReadRegister1 = a1;
    ReadRegister2 = a2;
    clear_start = st;
    if (rst) begin
      foreach (mem[i]) mem[i] = '0;
      sc = -1;
    end
    e.rd1 = m_read(a1, 1'b1);
    e.rd2 = m_read(a2, 1'b1);
    e.nb1 = m_read(a1, 1'b0);
    e.nb2 = m_read(a2, 1'b0);
    e.busy = m_busy();
    e.done = (sc == NR);
    q.push_back(e);
    @(posedge clk);
    if (!rst) begin
      if (m_busy()) begin
        mem[sc] = '0;
        sc++;
      end else begin
        if (we && int'(wa) != ZR) mem[wa] = wd;
        if (sc == NR) sc = -1;
        else if (st) sc = 0;
      end
    end
    #1;
  endtask

  task automatic chk(input string n, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("rd1", ReadData1, e.rd1);
      chk("rd2", ReadData2, e.rd2);
      chk("nb_rd1", nb_rd1, e.nb1);
      chk("nb_rd2", nb_rd2, e.nb2);
      chk("busy", {63'd0, clear_busy}, {63'd0, e.busy});
      chk("done", {63'd0, clear_done}, {63'd0, e.done});
      chk("nb_busy", {63'd0, nb_busy}, {63'd0, e.busy});
    end
  end

  function automatic logic [DW-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  initial begin
    logic [AW-1:0] a, b;
    reset_n = 1'b0;
    RegWrite = 1'b0;
    WriteRegister = '0;
    WriteData = '0;
    ReadRegister1 = '0;
    ReadRegister2 = '0;
    clear_start = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < NR / 2; i++)
      step(1, 0, 0, 0, AW'(2 * i), AW'(2 * i + 1), 0);
    step(0, 0, 0, 0, 0, 1, 0);

    step(0, 1, 5, 64'hDEADBEEF_01234567, 5, 6, 0);
    step(0, 1, 6, 64'h1, 5, 6, 0);
    step(0, 0, 0, 0, 5, 6, 0);
    step(0, 1, 31, '1, 31, 31, 0);
    step(0, 0, 0, 0, 31, 31, 0);
    step(0, 1, 7, 64'hAA, 7, 7, 0);
    step(0, 0, 0, 0, 7, 7, 0);

    for (int i = 0; i < NR - 1; i++)
      step(0, 1, AW'(i), rnd64() | 64'h1, AW'(i), AW'(30 - i), 0);
    step(0, 0, 0, 0, 0, 30, 1);
    for (int k = 0; k < NR + 3; k++) begin
      if (k == 2) step(0, 1, 3, 64'h3333, 3, 3, 0);
      else if (k == 3) step(0, 0, 0, 0, 3, 4, 0);
      else if (k == 10) step(0, 0, 0, 0, 0, 30, 0);
      else step(0, 0, 0, 0, AW'($urandom), AW'($urandom), k == 20);
    end
    for (int i = 0; i < NR / 2; i++)
      step(0, 0, 0, 0, AW'(2 * i), AW'(2 * i + 1), 0);

    for (int i = 0; i < 8; i++)
      step(0, 1, AW'(i), rnd64(), AW'(i), 0, 0);
    step(0, 0, 0, 0, 1, 2, 1);
    for (int k = 0; k < 10; k++) step(0, 0, 0, 0, AW'(k), 7, 0);
    step(1, 0, 0, 0, 1, 2, 0);
    step(0, 0, 0, 0, 3, 4, 0);
    step(0, 1, 9, 64'h99, 9, 9, 1);
    for (int k = 0; k < NR + 3; k++) step(0, 0, 0, 0, 9, AW'(k), 0);

    for (int n = 0; n < 600; n++) begin
      a = AW'($urandom);
      b = ($urandom_range(0, 3) == 0) ? WriteRegister : AW'($urandom);
      step($urandom_range(0, 199) == 0, $urandom_range(0, 1) == 1, AW'($urandom),
           rnd64(), a, b, $urandom_range(0, 39) == 0);
    end

    repeat (3) @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
